// File: rtl/ad936x_rx_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ad936x_rx_ctrl_pkg
// Description : Shared types and helpers for the AD936x RX capture sequencer.
//               Holds the capture FSM state encoding and the bytes-to-words
//               conversion for one source block.
// Revision    : 1.0 - initial release
// ============================================================================
package ad936x_rx_ctrl_pkg;

    // Capture sequencer states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // One 32-bit AXIS word carries one {I,Q} sample, i.e. four bytes.
    function automatic int words_per_block(input int bytes_per_block);
        return bytes_per_block / 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ad936x_rx_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ad936x_rx_capture_ctrl
// Description : Capture sequencer between the AD936x RX-to-AXIS32 converter
//               and the USB/DMA AXI-Stream sink. Arms on cmd_start, aligns
//               to a source block boundary, forwards whole blocks (a fixed
//               count or continuously until cmd_stop), then returns to idle.
//               Reports delivered blocks, sink stalls and framing errors.
// Ports       :
//   rx_clk_in, rx_resetn          - clock, async active-low reset
//   cmd_start, cmd_stop           - host command pulses
//   cfg_num_blocks                - block quota (0 = continuous)
//   s_axis_*                      - source stream from converter
//   m_axis_*                      - sink stream (zero-latency passthrough)
//   busy, done                    - capture status / end-of-capture pulse
//   blocks_done, stall_cnt        - delivered blocks / sink stall cycles
//   overflow, frame_err           - sticky loss and framing flags
// Revision    : 1.0 - initial release
// ============================================================================
module ad936x_rx_capture_ctrl
    import ad936x_rx_ctrl_pkg::*;
#(
    parameter int BYTES_PER_BLOCK = 512,
    parameter int BLK_W           = 16
) (
    input  logic              rx_clk_in,
    input  logic              rx_resetn,
    input  logic              cmd_start,
    input  logic              cmd_stop,
    input  logic [BLK_W-1:0]  cfg_num_blocks,
    input  logic [31:0]       s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic [31:0]       m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [3:0]        m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              done,
    output logic [BLK_W-1:0]  blocks_done,
    output logic [31:0]       stall_cnt,
    output logic              overflow,
    output logic              frame_err
);

    localparam int c_WORDS  = words_per_block(BYTES_PER_BLOCK);
    localparam int c_WCNT_W = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;
    localparam logic [c_WCNT_W-1:0] c_WCNT_MAX = c_WCNT_W'(c_WORDS - 1);

    state_t              r_state;
    logic [BLK_W-1:0]    r_num_blocks;
    logic [BLK_W-1:0]    r_blocks_done;
    logic [31:0]         r_stall_cnt;
    logic                r_overflow;
    logic                r_frame_err;
    logic                r_busy;
    logic                r_done;
    logic [c_WCNT_W-1:0] r_wcnt;

    logic                w_fwd;
    logic                w_hs_s;
    logic                w_hs_m;
    logic                w_blk_hs;
    logic [BLK_W-1:0]    w_blk_next;
    logic                w_quota_hit;

    // Passthrough only while forwarding; otherwise the source is drained
    // (ready held high) and nothing reaches the sink.
    assign w_fwd         = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tvalid = w_fwd & s_axis_tvalid;
    assign m_axis_tlast  = w_fwd & s_axis_tlast;
    assign m_axis_tkeep  = 4'hF;
    assign s_axis_tready = w_fwd ? m_axis_tready : 1'b1;

    assign w_hs_s      = s_axis_tvalid & s_axis_tready;
    assign w_hs_m      = m_axis_tvalid & m_axis_tready;
    assign w_blk_hs    = w_hs_m & m_axis_tlast;
    assign w_blk_next  = r_blocks_done + BLK_W'(1);
    assign w_quota_hit = (r_num_blocks != '0) && (w_blk_next == r_num_blocks);

    assign busy        = r_busy;
    assign done        = r_done;
    assign blocks_done = r_blocks_done;
    assign stall_cnt   = r_stall_cnt;
    assign overflow    = r_overflow;
    assign frame_err   = r_frame_err;

    always_ff @(posedge rx_clk_in or negedge rx_resetn) begin
        if (!rx_resetn) begin
            r_state       <= ST_IDLE;
            r_num_blocks  <= '0;
            r_blocks_done <= '0;
            r_stall_cnt   <= '0;
            r_overflow    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_wcnt        <= '0;
        end else begin
            r_done <= 1'b0;

            // Statistics and framing run for every forwarding cycle,
            // independent of which state transition happens below.
            if (w_fwd) begin
                if (s_axis_tvalid && !m_axis_tready) begin
                    r_overflow <= 1'b1;
                    if (r_stall_cnt != 32'hFFFF_FFFF) begin
                        r_stall_cnt <= r_stall_cnt + 32'd1;
                    end
                end
                if (w_hs_m) begin
                    if (m_axis_tlast) begin
                        if (r_wcnt != c_WCNT_MAX) begin
                            r_frame_err <= 1'b1;
                        end
                        r_wcnt <= '0;
                    end else if (r_wcnt == c_WCNT_MAX) begin
                        // Block ran long: flag it and restart the count so
                        // later blocks are judged on their own length.
                        r_frame_err <= 1'b1;
                        r_wcnt      <= '0;
                    end else begin
                        r_wcnt <= r_wcnt + c_WCNT_W'(1);
                    end
                end
                if (w_blk_hs) begin
                    r_blocks_done <= w_blk_next;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (cmd_start) begin
                        r_state       <= ST_ARMED;
                        r_busy        <= 1'b1;
                        r_num_blocks  <= cfg_num_blocks;
                        r_blocks_done <= '0;
                        r_stall_cnt   <= '0;
                        r_overflow    <= 1'b0;
                        r_frame_err   <= 1'b0;
                        r_wcnt        <= '0;
                    end
                end
                ST_ARMED: begin
                    if (cmd_stop) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_hs_s && s_axis_tlast) begin
                        // Next source word starts a fresh block.
                        r_state <= ST_RUN;
                        r_wcnt  <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_blk_hs) begin
                        if (w_quota_hit || cmd_stop) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else if (cmd_stop) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_blk_hs) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ad936x_rx_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ad936x_rx_capture_ctrl
// Description : Self-checking bench for ad936x_rx_capture_ctrl with four-word
//               blocks. A source stream of random blocks is built as a queue;
//               the expected sink stream is derived from it directly (the
//               blocks that follow the first end-of-block after arming).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ad936x_rx_capture_ctrl;

    localparam int BYTES_PER_BLOCK = 16;
    localparam int BLK_W           = 16;
    localparam int WORDS           = BYTES_PER_BLOCK / 4;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } word_t;

    logic             rx_clk_in;
    logic             rx_resetn;
    logic             cmd_start;
    logic             cmd_stop;
    logic [BLK_W-1:0] cfg_num_blocks;
    logic [31:0]      s_axis_tdata;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic             s_axis_tlast;
    logic [31:0]      m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic [3:0]       m_axis_tkeep;
    logic             m_axis_tlast;
    logic             busy;
    logic             done;
    logic [BLK_W-1:0] blocks_done;
    logic [31:0]      stall_cnt;
    logic             overflow;
    logic             frame_err;

    ad936x_rx_capture_ctrl #(
        .BYTES_PER_BLOCK (BYTES_PER_BLOCK),
        .BLK_W           (BLK_W)
    ) dut (
        .rx_clk_in      (rx_clk_in),
        .rx_resetn      (rx_resetn),
        .cmd_start      (cmd_start),
        .cmd_stop       (cmd_stop),
        .cfg_num_blocks (cfg_num_blocks),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tlast   (m_axis_tlast),
        .busy           (busy),
        .done           (done),
        .blocks_done    (blocks_done),
        .stall_cnt      (stall_cnt),
        .overflow       (overflow),
        .frame_err      (frame_err)
    );

    initial begin
        rx_clk_in = 1'b0;
        forever #5 rx_clk_in = ~rx_clk_in;
    end

    word_t       src_q[$];
    word_t       out_q[$];
    word_t       exp_q[$];
    logic [31:0] stall_hist[$];
    int          src_idx;
    int          done_cnt;
    bit          seen_valid;
    int          n_cmp;
    int          n_err;

    // ---------------- stimulus helpers ----------------
    task automatic new_stream();
        src_q.delete();
        out_q.delete();
        stall_hist.delete();
        src_idx    = 0;
        done_cnt   = 0;
        seen_valid = 1'b0;
    endtask

    task automatic add_block(input int len);
        word_t w;
        for (int i = 0; i < len; i++) begin
            w.data = $urandom;
            w.last = (i == len - 1);
            src_q.push_back(w);
        end
    endtask

    // One clock: drive inputs, observe at the falling edge, advance the
    // source pointer if it was accepted at the rising edge.
    task automatic step(input bit start, input bit stop, input bit vld_en, input bit rdy);
        bit hs;
        cmd_start     = start;
        cmd_stop      = stop;
        m_axis_tready = rdy;
        if (vld_en && src_idx < src_q.size()) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = src_q[src_idx].data;
            s_axis_tlast  = src_q[src_idx].last;
        end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
        end
        @(negedge rx_clk_in);
        if (done) done_cnt++;
        if (m_axis_tvalid) seen_valid = 1'b1;
        if (m_axis_tvalid && !m_axis_tready) stall_hist.push_back(m_axis_tdata);
        if (m_axis_tvalid && m_axis_tready) out_q.push_back({m_axis_tlast, m_axis_tdata});
        hs = s_axis_tvalid && s_axis_tready;
        @(posedge rx_clk_in);
        #1;
        if (hs) src_idx++;
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
    endtask

    // Consume 'pre' words while idle (discarded), then issue start with the
    // source paused so the arming point is the known index k.
    task automatic begin_capture(input int n, input int pre, output int k);
        for (int i = 0; i < pre; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        cfg_num_blocks = BLK_W'(n);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        k = src_idx;
        cfg_num_blocks = BLK_W'($urandom);
    endtask

    task automatic run_to_done(input bit gaps);
        for (int c = 0; c < 300 && done_cnt == 0; c++)
            step(1'b0, 1'b0, gaps ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Reference: the sink sees the 'count' words following the first
    // end-of-block at or after the arming index k.
    function automatic void build_expected(input int k, input int count);
        int j;
        j = k;
        while (j < src_q.size() && !src_q[j].last) j++;
        exp_q.delete();
        for (int i = 1; i <= count && (j + i) < src_q.size(); i++) exp_q.push_back(src_q[j + i]);
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (blocks_done !== '0 || stall_cnt !== 32'd0) begin n_err++;
            $display("FAIL reset_counters: blocks %0d stall %0d want 0 0", blocks_done, stall_cnt); end
        n_cmp++; if (overflow !== 1'b0 || frame_err !== 1'b0) begin n_err++;
            $display("FAIL reset_flags: ovf %b ferr %b want 0 0", overflow, frame_err); end
        n_cmp++; if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin n_err++;
            $display("FAIL reset_stream: mvalid %b sready %b want 0 1", m_axis_tvalid, s_axis_tready); end
        n_cmp++; if (m_axis_tkeep !== 4'hF) begin n_err++; $display("FAIL tkeep: got %h want f", m_axis_tkeep); end
        @(posedge rx_clk_in); #1;
        rx_resetn = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int k;
        new_stream();
        repeat (5) add_block(WORDS);
        begin_capture(2, 2, k);
        run_to_done(1'b1);
        build_expected(k, 2 * WORDS);
        n_cmp++; if (out_q.size() != exp_q.size()) begin n_err++;
            $display("FAIL basic_len: got %0d words want %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (out_q[i] !== exp_q[i]) begin n_err++;
                $display("FAIL basic_word%0d: got %h want %h", i, out_q[i], exp_q[i]); end
        end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt); end
        n_cmp++; if (blocks_done !== BLK_W'(2)) begin n_err++; $display("FAIL basic_blocks: got %0d want 2", blocks_done); end
        n_cmp++; if (busy !== 1'b0 || frame_err !== 1'b0) begin n_err++;
            $display("FAIL basic_status: busy %b ferr %b want 0 0", busy, frame_err); end
    endtask

    task automatic test_stop();
        int k;
        new_stream();
        repeat (6) add_block(WORDS);
        begin_capture(0, 1, k);
        for (int c = 0; c < 300 && out_q.size() < 2 * WORDS + 1; c++)
            step(1'b0, 1'b0, $urandom_range(0, 3) != 0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        run_to_done(1'b0);
        build_expected(k, 3 * WORDS);
        n_cmp++; if (out_q.size() != 3 * WORDS) begin n_err++;
            $display("FAIL stop_len: got %0d words want %0d", out_q.size(), 3 * WORDS); end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (out_q[i] !== exp_q[i]) begin n_err++;
                $display("FAIL stop_word%0d: got %h want %h", i, out_q[i], exp_q[i]); end
        end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL stop_done: got %0d pulses want 1", done_cnt); end
        n_cmp++; if (blocks_done !== BLK_W'(3) || busy !== 1'b0) begin n_err++;
            $display("FAIL stop_status: blocks %0d busy %b want 3 0", blocks_done, busy); end
    endtask

    task automatic test_stall();
        int k;
        new_stream();
        repeat (3) add_block(WORDS);
        begin_capture(1, 1, k);
        for (int c = 0; c < 100 && out_q.size() < 2; c++) step(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0);
        run_to_done(1'b0);
        build_expected(k, WORDS);
        n_cmp++; if (stall_cnt !== 32'd5) begin n_err++; $display("FAIL stall_cnt: got %0d want 5", stall_cnt); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL stall_ovf: got %b want 1", overflow); end
        n_cmp++; if (stall_hist.size() != 5) begin n_err++;
            $display("FAIL stall_cycles: got %0d want 5", stall_hist.size()); end
        for (int i = 0; i < stall_hist.size(); i++) begin
            n_cmp++; if (stall_hist[i] !== exp_q[2].data) begin n_err++;
                $display("FAIL stall_hold%0d: got %h want %h", i, stall_hist[i], exp_q[2].data); end
        end
        n_cmp++; if (out_q.size() != WORDS || out_q[WORDS-1] !== exp_q[WORDS-1]) begin n_err++;
            $display("FAIL stall_out: got %0d words want %0d", out_q.size(), WORDS); end
        n_cmp++; if (blocks_done !== BLK_W'(1) || done_cnt != 1) begin n_err++;
            $display("FAIL stall_done: blocks %0d pulses %0d want 1 1", blocks_done, done_cnt); end
    endtask

    task automatic test_frame_err();
        int k;
        new_stream();
        add_block(WORDS);
        add_block(WORDS - 1);
        add_block(WORDS);
        add_block(WORDS);
        begin_capture(2, 1, k);
        for (int c = 0; c < 100 && out_q.size() < WORDS - 1; c++) step(1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++; if (frame_err !== 1'b1 || blocks_done !== BLK_W'(1)) begin n_err++;
            $display("FAIL frame_short: ferr %b blocks %0d want 1 1", frame_err, blocks_done); end
        repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0);
        run_to_done(1'b0);
        build_expected(k, 2 * WORDS - 1);
        n_cmp++; if (out_q.size() != exp_q.size()) begin n_err++;
            $display("FAIL frame_len: got %0d words want %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (out_q[i] !== exp_q[i]) begin n_err++;
                $display("FAIL frame_word%0d: got %h want %h", i, out_q[i], exp_q[i]); end
        end
        n_cmp++; if (blocks_done !== BLK_W'(2) || done_cnt != 1) begin n_err++;
            $display("FAIL frame_done: blocks %0d pulses %0d want 2 1", blocks_done, done_cnt); end
        n_cmp++; if (stall_cnt !== 32'd2 || overflow !== 1'b1 || frame_err !== 1'b1) begin n_err++;
            $display("FAIL frame_stats: stall %0d ovf %b ferr %b want 2 1 1", stall_cnt, overflow, frame_err); end
    endtask

    task automatic test_arm_stop();
        new_stream();
        add_block(WORDS);
        for (int pass = 0; pass < 2; pass++) begin
            cfg_num_blocks = BLK_W'(3);
            step(1'b1, 1'b0, 1'b0, 1'b1);
            n_cmp++; if (busy !== 1'b1 || overflow !== 1'b0 || frame_err !== 1'b0 || stall_cnt !== 32'd0) begin n_err++;
                $display("FAIL arm%0d_clear: busy %b ovf %b ferr %b stall %0d want 1 0 0 0",
                         pass, busy, overflow, frame_err, stall_cnt); end
            step(1'b0, 1'b0, 1'b1, 1'b1);
            step(1'b0, 1'b1, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b1);
            n_cmp++; if (busy !== 1'b0 || done_cnt != 0 || seen_valid) begin n_err++;
                $display("FAIL arm%0d_stop: busy %b pulses %0d mvalid_seen %b want 0 0 0",
                         pass, busy, done_cnt, seen_valid); end
        end
    endtask

    task automatic test_reset_mid_run();
        int k;
        new_stream();
        repeat (8) add_block(WORDS);
        begin_capture(0, 2, k);
        for (int c = 0; c < 200 && out_q.size() < WORDS + 2; c++) step(1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        rx_resetn = 1'b0;
        #1;
        n_cmp++; if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1 || busy !== 1'b0) begin n_err++;
            $display("FAIL async_rst_stream: mvalid %b sready %b busy %b want 0 1 0",
                     m_axis_tvalid, s_axis_tready, busy); end
        n_cmp++; if (blocks_done !== '0 || stall_cnt !== 32'd0 || done !== 1'b0) begin n_err++;
            $display("FAIL async_rst_counters: blocks %0d stall %0d done %b want 0 0 0",
                     blocks_done, stall_cnt, done); end
        @(posedge rx_clk_in); #1;
        rx_resetn = 1'b1;
        new_stream();
        repeat (3) add_block(WORDS);
        begin_capture(1, 3, k);
        run_to_done(1'b1);
        build_expected(k, WORDS);
        n_cmp++; if (out_q.size() != WORDS) begin n_err++;
            $display("FAIL rerun_len: got %0d words want %0d", out_q.size(), WORDS); end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (out_q[i] !== exp_q[i]) begin n_err++;
                $display("FAIL rerun_word%0d: got %h want %h", i, out_q[i], exp_q[i]); end
        end
        n_cmp++; if (blocks_done !== BLK_W'(1) || done_cnt != 1) begin n_err++;
            $display("FAIL rerun_done: blocks %0d pulses %0d want 1 1", blocks_done, done_cnt); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        rx_resetn      = 1'b0;
        cmd_start      = 1'b0;
        cmd_stop       = 1'b0;
        cfg_num_blocks = '0;
        s_axis_tdata   = '0;
        s_axis_tvalid  = 1'b0;
        s_axis_tlast   = 1'b0;
        m_axis_tready  = 1'b1;
        new_stream();
        repeat (2) @(posedge rx_clk_in);
        test_reset();
        test_basic();
        test_stop();
        test_stall();
        test_frame_err();
        test_arm_stop();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
